// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int TickCntWidth = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART serializer: pops the TX FIFO and shifts one LSB-first frame per word onto tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DataBits  = 8,
  parameter int StopTicks = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_tick_i,
  input  logic                empty_i,
  input  logic [DataBits-1:0] r_data_i,
  output logic                rd_o,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [TickCntWidth-1:0] SLast    = TickCntWidth'(OVERSAMPLE - 1);
  localparam logic [TickCntWidth-1:0] StopLast = TickCntWidth'(StopTicks - 1);
  localparam logic [2:0]              NLast    = 3'(DataBits - 1);

  tx_state_e               r_state, w_state_next;
  logic [TickCntWidth-1:0] r_s, w_s_next;
  logic [2:0]              r_n, w_n_next;
  logic [DataBits-1:0]     r_b, w_b_next;
  logic                    r_par, w_par_next;
  logic                    r_tx, w_tx_next;
  logic                    r_rd, w_rd_next;
  logic                    r_busy, w_busy_next;
  logic                    r_done, w_done_next;

  // Outputs are registered from the next state, so tx_o tracks the state with no glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= TX_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
      r_rd    <= w_rd_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_par_next   = r_par;
    w_rd_next    = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      TX_IDLE: begin
        // The word is latched here, before the pop, so the FIFO pointer move cannot disturb it.
        if (!empty_i) begin
          w_b_next     = r_data_i;
          w_par_next   = ^r_data_i;
          w_s_next     = '0;
          w_rd_next    = 1'b1;
          w_state_next = TX_START;
        end
      end
      TX_START: begin
        if (s_tick_i) begin
          if (r_s == SLast) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = TX_DATA;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (s_tick_i) begin
          if (r_s == SLast) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == NLast) begin
`ifdef UART_TX_PARITY_EN
              w_state_next = TX_PARITY;
`else
              w_state_next = TX_STOP;
`endif
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (s_tick_i) begin
          if (r_s == SLast) begin
            w_s_next     = '0;
            w_state_next = TX_STOP;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
`endif
      TX_STOP: begin
        if (s_tick_i) begin
          if (r_s == StopLast) begin
            w_s_next     = '0;
            w_done_next  = 1'b1;
            w_state_next = TX_IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_busy_next = (w_state_next != TX_IDLE);
    case (w_state_next)
      TX_START:  w_tx_next = 1'b0;
      TX_DATA:   w_tx_next = w_b_next[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: w_tx_next = w_par_next;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  assign tx_o   = r_tx;
  assign rd_o   = r_rd;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor decodes tx_o and compares.
// Build with UART_TX_PARITY_EN defined to exercise the parity frames as well.
module tb_uart_tx;

  localparam int STOP_TICKS = 32;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAST_DATA_TICK = 16 * (1 + 8 + PAR_BITS);
  localparam int TOTAL_TICKS    = LAST_DATA_TICK + STOP_TICKS;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    bit          b2b;
  } frame_t;

  logic       clk;
  logic       rst_ni;
  logic       s_tick_i;
  logic       empty_i;
  logic [7:0] r_data_i;
  logic       rd_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rdPulses = 0;
  int framesDone = 0;
  int spuriousDone = 0;
  int monTick = 0;
  bit monInFrame = 0;

  logic [7:0] fifo[$];
  frame_t     expQ[$];

  uart_tx #(
    .DataBits (8),
    .StopTicks(STOP_TICKS)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .s_tick_i(s_tick_i),
    .empty_i (empty_i),
    .r_data_i(r_data_i),
    .rd_o    (rd_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 16 clocks, changed just after the rising edge.
  initial begin
    int tickCnt;
    tickCnt  = 0;
    s_tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tickCnt  = (tickCnt + 1) % 16;
      s_tick_i = (tickCnt == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void driveFifo();
    empty_i  = (fifo.size() == 0);
    r_data_i = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endfunction

  // Expected line levels are built from the word and a hand-computed parity bit.
  task automatic applyStimulus(input logic [7:0] word, input logic parity, input bit b2b);
    frame_t f;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = word[i];
    f.bits[9]            = (PAR_BITS == 1) ? parity : 1'b1;
    f.bits[9 + PAR_BITS] = 1'b1;
    f.nbits = 10 + PAR_BITS;
    f.b2b   = b2b;
    expQ.push_back(f);
    fifo.push_back(word);
    driveFifo();
  endtask

  task automatic waitFrames(input int target, input int budget);
    for (int i = 0; i < budget && framesDone < target; i++) @(posedge clk);
    #1;
    checkOutput("frames completed", framesDone, target);
  endtask

  // FIFO model: pops on the edge that ends an rd_o cycle.
  initial begin
    bit popNow;
    forever begin
      @(negedge clk);
      popNow = rd_o;
      if (rd_o) rdPulses++;
      @(posedge clk);
      #1;
      if (popNow && fifo.size() != 0) void'(fifo.pop_front());
      driveFifo();
    end
  end

  // Monitor: decodes each frame by counting ticks and compares against the scoreboard.
  initial begin
    frame_t cur;
    bit     waitDone;
    int     lastDataCyc;
    int     prevDoneCyc;
    waitDone    = 0;
    lastDataCyc = 0;
    prevDoneCyc = -100;
    cur.bits    = '1;
    cur.nbits   = 10;
    cur.b2b     = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        monInFrame = 0;
        waitDone   = 0;
        continue;
      end
      if (waitDone) begin
        checkOutput($sformatf("frame%0d done_o", framesDone), done_o, 1);
        checkOutput($sformatf("frame%0d busy_o at done", framesDone), busy_o, 0);
        checkOutput($sformatf("frame%0d stop clk", framesDone), cyc - (lastDataCyc + 1), STOP_TICKS * 16);
        prevDoneCyc = cyc;
        waitDone    = 0;
        monInFrame  = 0;
        framesDone++;
      end else if (done_o) begin
        spuriousDone++;
      end
      if (!monInFrame && tx_o === 1'b0) begin
        monInFrame = 1;
        monTick    = 0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected frame", 1, 0);
        end else begin
          cur = expQ.pop_front();
        end
        checkOutput($sformatf("frame%0d busy_o", framesDone), busy_o, 1);
        if (cur.b2b) checkOutput($sformatf("frame%0d b2b gap", framesDone), cyc - prevDoneCyc, 1);
      end
      if (monInFrame && !waitDone && s_tick_i) begin
        monTick++;
        if ((monTick - 1) % 16 == 7 && (monTick - 1) / 16 < cur.nbits)
          checkOutput($sformatf("frame%0d bit%0d", framesDone, (monTick - 1) / 16), tx_o,
                      cur.bits[(monTick - 1) / 16]);
        if (monTick == LAST_DATA_TICK) lastDataCyc = cyc;
        if (monTick == TOTAL_TICKS) waitDone = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int viol;
    rst_ni   = 1'b0;
    empty_i  = 1'b1;
    r_data_i = 8'h00;

    // Reset held with a word waiting: nothing may move.
    applyStimulus(8'hA5, 1'b0, 0);
    repeat (5) @(negedge clk);
    checkOutput("reset tx_o", tx_o, 1);
    checkOutput("reset rd_o", rd_o, 0);
    checkOutput("reset busy_o", busy_o, 0);
    checkOutput("reset done_o", done_o, 0);
    checkOutput("reset pops", rdPulses, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    waitFrames(1, 4000);
    checkOutput("single word pops", rdPulses, 1);

    $display("[TB] empty FIFO idle check");
    viol = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || rd_o !== 1'b0 || busy_o !== 1'b0) viol++;
    end
    checkOutput("idle violations", viol, 0);

    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'hFF, 1'b0, 1);
    waitFrames(3, 8000);
    checkOutput("back-to-back pops", rdPulses, 3);

    @(posedge clk);
    #1;
    applyStimulus(8'h52, 1'b1, 0);
    for (int i = 0; i < 4000 && !(monInFrame && monTick >= 72); i++) @(posedge clk);
    checkOutput("reached data bit 3", (monInFrame && monTick >= 72), 1);
    @(posedge clk);
    #2;
    checkOutput("tx_o before reset", tx_o, 0);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("async reset tx_o", tx_o, 1);
    checkOutput("async reset busy_o", busy_o, 0);
    applyStimulus(8'h81, 1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rd_o held in reset", rd_o, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    waitFrames(4, 4000);
    checkOutput("pops after reset", rdPulses, 5);

`ifdef UART_TX_PARITY_EN
    @(posedge clk);
    #1;
    applyStimulus(8'h07, 1'b1, 0);
    applyStimulus(8'h03, 1'b0, 1);
    waitFrames(6, 8000);
    checkOutput("parity pops", rdPulses, 7);
`endif

    repeat (20) @(negedge clk);
    checkOutput("spurious done_o", spuriousDone, 0);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serializer that drains the transmit FIFO and drives the serial line. Whenever the FIFO is non-empty, it pops one word and transmits one frame, LSB first, on `tx_o`: a start bit, `DataBits` data bits, an optional parity bit, then the stop period. Bit timing comes from an external 16x-oversampling tick (`s_tick_i`) shared with the receiver. The block sits between the TX FIFO read port and the pad.

## Interface
- `DataBits`, 8: data bits per frame, legal range 5..8.
- `StopTicks`, 16: stop-period length in `s_tick_i` ticks; 16/24/32 give 1/1.5/2 stop bits; legal range 16..63.
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assertion, active-low.
- `s_tick_i`  in  1  oversampling tick, one `clk_i` cycle wide, 16 per bit time.
- `empty_i`  in  1  FIFO empty flag.
- `r_data_i`  in  `DataBits`  FIFO head word; valid whenever `empty_i`=0.
- `rd_o`  out  1  FIFO pop strobe, one cycle wide.
- `tx_o`  out  1  serial line; idle high.
- `busy_o`  out  1  high while a frame is in progress.
- `done_o`  out  1  one-cycle pulse at the end of each stop period.

## Operation
- States: IDLE, START, DATA, PARITY (only with the parity macro), STOP.
- Tick counter `s` is 6 bits; bit counter `n` is 3 bits; shift register `b` is `DataBits` wide. The counters advance only on cycles where `s_tick_i`=1.
- **IDLE:** `tx_o`=1.
  - If `empty_i`=0, the block loads `b` with `r_data_i`, clears `s`, sets `rd_o` next cycle and goes to START.
  - It does not wait for a tick to start the frame.
- **START:** `tx_o`=0. On the tick where `s`=15, it clears `s`, clears `n` and goes to DATA.
- **DATA:** `tx_o`=`b[0]`. On the tick where `s`=15, it clears `s` and shifts `b` right by one.
  - If `n`=`DataBits`-1, it goes to PARITY or STOP.
  - Otherwise it increments `n`.
- **PARITY:** `tx_o` = XOR of the latched word (even parity). After 16 ticks it goes to STOP.
- **STOP:** `tx_o`=1. On the tick where `s`=`StopTicks`-1, it pulses `done_o` and goes to IDLE.
- `busy_o`=1 in every state except IDLE.
- `r_data_i` and `empty_i` are ignored outside IDLE.
- The block performs exactly one pop per frame.

## Timing
- **Reset values:** `tx_o`=1, `rd_o`=0, `busy_o`=0, `done_o`=0, state IDLE, all counters 0.
- All outputs are registered, so `tx_o` is glitch-free.
- **Pop timing:**
  - `rd_o` is high for exactly the cycle after the IDLE->START transition.
  - The FIFO pops on that edge.
  - The word has already been latched, so the pointer advance cannot corrupt the frame.
- **Frame length:** (1 + `DataBits` + parity + `StopTicks`/16) bit times.
  - With defaults: 160 ticks = 2560 clk cycles at tick period 16.
- **Back-to-back frames:** when `done_o` pulses and `empty_i`=0, the next start bit begins 1 clk after the return to IDLE, so the line is high for `StopTicks` ticks plus 1 clk.
- **Reset mid-frame:** `tx_o` returns to 1 immediately, without waiting for a clock edge. The word already popped is lost and no `done_o` is issued.
- **`empty_i` rising during a frame:** no effect on the current frame.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state exists and one even-parity bit (16 ticks) is inserted between the last data bit and the stop period.
- **Undefined:** there is no PARITY state and DATA goes directly to STOP.
- The port list is identical in both cases.

## Structure
- Package `uart_pkg` holds:
  - the TX state enum typedef;
  - `OVERSAMPLE` = 16;
  - the tick-counter width constant (6).
- The receiver uses the same package.
- No sub-module: the baud tick generator stays outside this block and is shared with the receiver.

## Test plan
Unless stated otherwise, `s_tick_i` pulses every 16 clk, giving 256 clk per bit.

1. **Reset values:** hold `rst_ni`=0 for 5 clk, with `empty_i`=0 -> `tx_o`=1, `rd_o`=0, `busy_o`=0, and no pop occurs.
2. **Single word:** present 0xA5 with `empty_i`=0 for one pop.
   - Exactly one `rd_o` pulse occurs.
   - `tx_o` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 256 clk.
   - `done_o` pulses once, 2560 clk after start.
3. **Empty FIFO:** hold `empty_i`=1 for 5000 clk -> `tx_o` stays 1, and `rd_o` and `busy_o` stay 0.
4. **Back-to-back:** send 0x00 then 0xFF.
   - Exactly two `rd_o` pulses occur.
   - The second start bit falls 1 clk after the first `done_o`.
   - Data line levels are all 0 in the first frame, all 1 in the second.
5. **Reset mid-frame, plus stop length:**
   - Pull `rst_ni` low during data bit 3 -> `tx_o`=1 with no clock edge, and `busy_o`=0.
   - After release with `empty_i`=0, a fresh frame starts.
   - With `StopTicks`=32, the stop period measures 512 clk.
6. **Parity (`UART_TX_PARITY_EN` defined):** send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Each frame is 11 bit times.
